// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory-mapped I/O bank.
//   MMIO_BASE          default address window base
//   CH_*               channel index map of the Hack-style board
//   *_MASK_DEF         default channel-kind masks (bit i = channel i)
//   ch_kind_e/ch_kind  resolves a channel's kind from the three mask bits
package mmio_pkg;

  localparam logic [15:0] MMIO_BASE = 16'h0F00;

  localparam int CH_LED       = 0;
  localparam int CH_BUTTON    = 1;
  localparam int CH_UART_TX   = 2;
  localparam int CH_UART_RX   = 3;
  localparam int CH_SPI       = 4;
  localparam int CH_SRAM_ADDR = 5;
  localparam int CH_SRAM_DATA = 6;
  localparam int CH_GO        = 7;
  localparam int CH_LCD8      = 8;
  localparam int CH_LCD16     = 9;
  localparam int CH_RTP       = 10;
  localparam int CH_DEBUG0    = 11;
  localparam int CH_DEBUG1    = 12;
  localparam int CH_DEBUG2    = 13;
  localparam int CH_DEBUG3    = 14;
  localparam int CH_DEBUG4    = 15;

  localparam logic [15:0] OUT_MASK_DEF = 16'hFFF5;
  localparam logic [15:0] IN_MASK_DEF  = 16'h0002;
  localparam logic [15:0] EVT_MASK_DEF = 16'h0008;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_OUT  = 2'd1,
    KIND_IN   = 2'd2,
    KIND_EVT  = 2'd3
  } ch_kind_e;

  // Overlapping masks resolve as EVT over IN over OUT.
  function automatic ch_kind_e ch_kind(input logic evt_bit, input logic in_bit,
                                       input logic out_bit);
    if (evt_bit)      return KIND_EVT;
    else if (in_bit)  return KIND_IN;
    else if (out_bit) return KIND_OUT;
    else              return KIND_NONE;
  endfunction

endpackage

// File: rtl/mmio_bank_if.sv
// mmio_bank_if: CPU-side bus of the I/O bank (addressM/writeM/outM/inM).
//   address  CPU data address
//   load     write strobe, qualified inside the bank by its own decode
//   in       CPU write data
//   out      read data, combinational, valid while hit is high
//   hit      address lies in the bank window; selects out in the read mux
// There is no handshake: a write is accepted on the rising edge where
// load && hit, and reads are zero-latency.
interface mmio_bank_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      address;
  logic             load;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             hit;

  modport master (output address, load, in, input out, hit);
  modport slave  (input address, load, in, output out, hit);
endinterface

// File: rtl/mmio_in_channel.sv
// mmio_in_channel: input path for one WIDTH-bit channel.
//   clk, reset  clock, asynchronous active-high reset
//   pins        asynchronous external input word
//   wr, wdata   write-1-to-clear request (EVT mode only)
//   rdata       stable word (IN mode) or sticky event bits (EVT mode)
//   pending     any sticky bit set (always 0 in IN mode)
// Two-flop synchroniser, then the stable stage. With MMIO_DEBOUNCE_EN
// defined, stable only follows a synced word that stayed unchanged for
// DEBOUNCE_CYCLES edges; otherwise stable is the synchroniser output.
module mmio_in_channel #(
  parameter int WIDTH           = 16,
  parameter bit IS_EVT          = 1'b0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             pending
);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [WIDTH-1:0] prev, sticky, rise, clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  // Any change restarts the window; the counter saturates at CNT_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == CNT_MAX) stable <= cand;
    end
  end
`else
  assign stable = sync2;
`endif

  assign rise = stable & ~prev;
  assign clr  = wr ? wdata : '0;

  // OR-ing rise after the clear makes a same-cycle set win over W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      sticky <= '0;
    end else begin
      prev   <= stable;
      sticky <= (sticky & ~clr) | rise;
    end
  end

  assign rdata   = IS_EVT ? sticky : stable;
  assign pending = IS_EVT ? (|sticky) : 1'b0;

endmodule

// File: rtl/mmio_bank.sv
// mmio_bank: parametrised memory-mapped I/O bank for the Hack-style CPU bus.
//   clk, reset  clock, asynchronous active-high reset
//   bus         mmio_bank_if.slave: address/load/in from the CPU, out/hit back
//   pins_in     external inputs, channel i at [i*WIDTH +: WIDTH]
//   pins_out    output-channel values, same packing (0 for other kinds)
//   irq         OR of all sticky event bits
// Each channel is an output register, a synchronised input or a sticky
// rising-edge event register with write-1-to-clear, chosen by the masks.
// Optional: MMIO_DEBOUNCE_EN adds a debounce stage to IN/EVT channels.
module mmio_bank
  import mmio_pkg::*;
#(
  parameter int                WIDTH           = 16,
  parameter int                NUM_CH          = 16,
  parameter logic [15:0]       BASE_ADDR       = MMIO_BASE,
  parameter logic [NUM_CH-1:0] OUT_MASK        = NUM_CH'(OUT_MASK_DEF),
  parameter logic [NUM_CH-1:0] IN_MASK         = NUM_CH'(IN_MASK_DEF),
  parameter logic [NUM_CH-1:0] EVT_MASK        = NUM_CH'(EVT_MASK_DEF),
  parameter int                DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_bank_if.slave              bus,
  input  logic [NUM_CH*WIDTH-1:0] pins_in,
  output logic [NUM_CH*WIDTH-1:0] pins_out,
  output logic                    irq
);

  localparam int AB = $clog2(NUM_CH);

  logic              hit;
  logic [AB-1:0]     idx;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] pend;
  logic [WIDTH-1:0]  ch_val [NUM_CH];

  assign hit = (bus.address[15:AB] == BASE_ADDR[15:AB]);
  assign idx = bus.address[AB-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam ch_kind_e KIND = ch_kind(EVT_MASK[i], IN_MASK[i], OUT_MASK[i]);

    assign wr_en[i] = bus.load && hit && (idx == AB'(i));

    if (KIND == KIND_OUT) begin : g_out
      logic [WIDTH-1:0] r;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)         r <= '0;
        else if (wr_en[i]) r <= bus.in;
      end
      assign ch_val[i]                  = r;
      assign pins_out[i*WIDTH +: WIDTH] = r;
      assign pend[i]                    = 1'b0;
    end else if (KIND == KIND_IN || KIND == KIND_EVT) begin : g_in
      mmio_in_channel #(
        .WIDTH           (WIDTH),
        .IS_EVT          (KIND == KIND_EVT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_in (
        .clk     (clk),
        .reset   (reset),
        .pins    (pins_in[i*WIDTH +: WIDTH]),
        .wr      (wr_en[i]),
        .wdata   (bus.in),
        .rdata   (ch_val[i]),
        .pending (pend[i])
      );
      assign pins_out[i*WIDTH +: WIDTH] = '0;
    end else begin : g_none
      assign ch_val[i]                  = '0;
      assign pins_out[i*WIDTH +: WIDTH] = '0;
      assign pend[i]                    = 1'b0;
    end
  end

  assign bus.out = hit ? ch_val[idx] : '0;
  assign bus.hit = hit;
  assign irq     = |pend;

  // Pins of output/unassigned channels and their write enables are
  // legitimately unconnected for some mask settings.
  logic unused_bits;
  assign unused_bits = ^{pins_in, wr_en};

endmodule

// File: tb/tb_mmio_bank.sv
module tb_mmio_bank;
  import mmio_pkg::*;

  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N*W-1:0] pins_in;
  logic [N*W-1:0] pins_out;
  logic irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_bank_if #(.WIDTH(W)) bus ();

  mmio_bank dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .pins_in  (pins_in),
    .pins_out (pins_out),
    .irq      (irq)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // h1/h2/h3: pin words sampled on the last three rising edges (h1 newest).
  // An input is readable two edges after it is sampled; an event compares
  // the readable word with the one from the edge before.
  logic [W-1:0] m_out    [N];
  logic [W-1:0] m_sticky [N];
  logic [W-1:0] h1 [N];
  logic [W-1:0] h2 [N];
  logic [W-1:0] h3 [N];
  logic [15:0]  out_mask = OUT_MASK_DEF;
  logic [15:0]  in_mask  = IN_MASK_DEF;
  logic [15:0]  evt_mask = EVT_MASK_DEF;

  function automatic bit k_evt(int i); return evt_mask[i]; endfunction
  function automatic bit k_in(int i);  return !evt_mask[i] && in_mask[i]; endfunction
  function automatic bit k_out(int i); return !evt_mask[i] && !in_mask[i] && out_mask[i]; endfunction

  function automatic bit m_hit(logic [15:0] a);
    return a[15:4] == 12'h0F0;
  endfunction

  function automatic logic [W-1:0] exp_read(logic [15:0] a);
    int i;
    if (!m_hit(a)) return '0;
    i = int'(a[3:0]);
    if (k_out(i)) return m_out[i];
    if (k_in(i))  return h2[i];
    if (k_evt(i)) return m_sticky[i];
    return '0;
  endfunction

  function automatic logic exp_irq();
    logic r = 1'b0;
    for (int i = 0; i < N; i++) if (k_evt(i)) r |= (m_sticky[i] != '0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = '0; m_sticky[i] = '0; h1[i] = '0; h2[i] = '0; h3[i] = '0;
    end
  endtask

  task automatic model_edge();
    bit wr;
    for (int i = 0; i < N; i++) begin
      wr = bus.load && m_hit(bus.address) && (int'(bus.address[3:0]) == i);
      if (k_evt(i))
        m_sticky[i] = (m_sticky[i] & ~(wr ? bus.in : '0)) | (h2[i] & ~h3[i]);
      else if (k_out(i) && wr)
        m_out[i] = bus.in;
      h3[i] = h2[i];
      h2[i] = h1[i];
      h1[i] = pins_in[i*W +: W];
    end
  endtask

  task automatic compare_all();
    check("out", bus.out, exp_read(bus.address));
    check("hit", bus.hit, m_hit(bus.address));
    check("irq", irq, exp_irq());
    for (int i = 0; i < N; i++)
      check($sformatf("pins_out%0d", i), pins_out[i*W +: W], k_out(i) ? m_out[i] : '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] a, input logic ld, input logic [W-1:0] d);
    bus.address = a;
    bus.load    = ld;
    bus.in      = d;
  endtask

  task automatic set_pin(input int ch, input logic [W-1:0] v);
    pins_in[ch*W +: W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    pins_in = '0;
    drive(16'h0F00, 1'b0, '0);
    model_reset();
    #1;
    check("rst_pins_out", {31'd0, |pins_out}, 32'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_out", bus.out, 16'h0000);
    #11 reset = 1'b0;

`ifdef MMIO_DEBOUNCE_EN
    drive(16'h0F01, 1'b0, '0);
    set_pin(CH_BUTTON, 16'hFFFF);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) set_pin(CH_BUTTON, 16'h0000);
      @(posedge clk); #1;
      check("glitch_hidden", bus.out, 16'h0000);
    end
    set_pin(CH_BUTTON, 16'h1234);
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; end
    check("debounced", bus.out, 16'h1234);
`else
    // 1: output register write and read-back
    drive(16'h0F00, 1'b1, 16'h0003);
    step();
    check("t1_pins_out", pins_out[15:0], 16'h0003);
    check("t1_out", bus.out, 16'h0003);
    check("t1_hit", bus.hit, 1'b1);
    drive(16'h0F00, 1'b0, '0);

    // 2: synchronised input latency, writes ignored
    set_pin(CH_BUTTON, 16'hA5A5);
    drive(16'h0F01, 1'b0, '0);
    #1 check("t2_pre", bus.out, 16'h0000);
    step();
    check("t2_edge1", bus.out, 16'h0000);
    step();
    check("t2_edge2", bus.out, 16'hA5A5);
    drive(16'h0F01, 1'b1, 16'hFFFF);
    step();
    check("t2_wr_ignored", bus.out, 16'hA5A5);
    check("t2_no_drive", pins_out[31:16], 16'h0000);

    // 3: sticky event and write-1-to-clear
    set_pin(CH_UART_RX, 16'h0011);
    drive(16'h0F03, 1'b0, '0);
    step();
    step();
    check("t3_irq_edge2", irq, 1'b0);
    step();
    check("t3_sticky", bus.out, 16'h0011);
    check("t3_irq", irq, 1'b1);
    drive(16'h0F03, 1'b1, 16'h0001);
    step();
    check("t3_clr1", bus.out, 16'h0010);
    check("t3_irq_hold", irq, 1'b1);
    drive(16'h0F03, 1'b1, 16'h0010);
    step();
    check("t3_clr2", bus.out, 16'h0000);
    check("t3_irq_low", irq, 1'b0);
    drive(16'h0F03, 1'b0, '0);

    // 4: rise and clear on the same bit in the same cycle
    set_pin(CH_UART_RX, 16'h0015);
    step();
    step();
    drive(16'h0F03, 1'b1, 16'h0004);
    step();
    check("t4_set_wins", bus.out, 16'h0004);
    drive(16'h0F03, 1'b0, '0);

    // 5: write outside the window
    drive(16'h0E05, 1'b1, 16'hFFFF);
    #1;
    check("t5_hit", bus.hit, 1'b0);
    check("t5_out", bus.out, 16'h0000);
    step();
    check("t5_ch0", pins_out[15:0], 16'h0003);
    check("t5_ch5", pins_out[95:80], 16'h0000);
    drive(16'h0F03, 1'b0, '0);

    // 6: asynchronous reset with a pending event
    #2 reset = 1'b1;
    #1;
    check("t6_pins_out", {31'd0, |pins_out}, 32'd0);
    check("t6_irq", irq, 1'b0);
    check("t6_out_ch3", bus.out, 16'h0000);
    bus.address = 16'h0F00;
    #1 check("t6_out_ch0", bus.out, 16'h0000);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    drive(16'h0F03, 1'b0, '0);
    step();
    step();
    check("t6_rel_edge2", bus.out, 16'h0000);
    step();
    check("t6_rel_edge3", bus.out, 16'h0015);
    check("t6_rel_irq", irq, 1'b1);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) bus.address = 16'($urandom);
      else bus.address = {12'h0F0, 4'($urandom_range(0, 15))};
      bus.load = ($urandom_range(0, 2) == 0);
      bus.in   = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        if (i == CH_BUTTON || i == CH_UART_RX) begin
          if ($urandom_range(0, 3) == 0) set_pin(i, 16'($urandom));
        end else begin
          set_pin(i, 16'($urandom));
        end
      end
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
